// File: rtl/sram_poc_pkg.sv
// Shared definitions for the flop-array SRAM responder.
//  - state_t: clear-sweep FSM states (ST_CLEAR, ST_READY)
//  - LANE_W / LANES: byte-lane width and lane count for the default 32-bit port
//  - lane_lo(): lowest bit index of a byte lane inside a data word
package sram_poc_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam int LANE_W     = 8;
    localparam int DATA_W_DEF = 32;
    localparam int LANES      = DATA_W_DEF / LANE_W;

    // Lowest bit index of byte lane 'lane'
    function automatic int lane_lo(input int lane);
        return lane * LANE_W;
    endfunction

endpackage

// File: rtl/sram_lane_parity.sv
// Even-parity generator for one byte lane.
// Ports:
//   lane_data   in  8  byte lane data
//   lane_parity out 1  even parity bit (XOR of all data bits)
module sram_lane_parity
    import sram_poc_pkg::*;
(
    input  logic [LANE_W-1:0] lane_data,
    output logic              lane_parity
);

    assign lane_parity = ^lane_data;

endmodule

// File: rtl/sram_1rw_responder.sv
// Flop-array emulator of a 1rw SRAM macro (responder side of csb/web/wmask/addr/din/dout).
// After reset a clear sweep writes zero into every word (init_busy high meanwhile);
// afterwards reads have one cycle of latency and writes are byte-masked.
// Optional feature: define RAM_PARITY_EN to store one even-parity bit per byte lane.
// Ports:
//   clk         in   1         port clock, rising edge
//   rst_n       in   1         synchronous active-low reset
//   ram_csb0    in   1         chip select, active low
//   ram_web0    in   1         write enable, active low
//   ram_wmask0  in   DATA_W/8  byte write mask
//   ram_addr0   in   ADDR_W    word address
//   ram_din0    in   DATA_W    write data
//   ram_dout0   out  DATA_W    registered read data
//   init_busy   out  1         clear sweep in progress
//   addr_err    out  1         one-cycle pulse after an access with addr >= DEPTH
//   parity_inj  in   1         invert stored parity of written lanes (parity build only)
//   parity_err  out  1         read parity mismatch, aligned with ram_dout0
module sram_1rw_responder
    import sram_poc_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ram_csb0,
    input  logic                     ram_web0,
    input  logic [DATA_W/8-1:0]      ram_wmask0,
    input  logic [ADDR_W-1:0]        ram_addr0,
    input  logic [DATA_W-1:0]        ram_din0,
    output logic [DATA_W-1:0]        ram_dout0,
    output logic                     init_busy,
    output logic                     addr_err,
    input  logic                     parity_inj,
    output logic                     parity_err
);

    localparam int                NLANES   = DATA_W / LANE_W;
    localparam int                PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem_r [DEPTH];

    state_t            state_r;
    logic [PTR_W-1:0]  clr_ptr_r;
    logic [DATA_W-1:0] dout_r;
    logic              init_busy_r;
    logic              addr_err_r;
    logic              parity_err_r;

    logic              in_range_s;
    logic [PTR_W-1:0]  idx_s;
    logic [DATA_W-1:0] rd_word_s;
    logic              wr_sel_s;
    logic              rd_sel_s;
    logic              access_s;
    logic              par_bad_s;

    // Address decode: upper address space beyond DEPTH is unbacked
    assign in_range_s = ({1'b0, ram_addr0} < DEPTH_L);
    assign idx_s      = ram_addr0[PTR_W-1:0];
    assign rd_word_s  = mem_r[idx_s];
    assign access_s   = (state_r == ST_READY) && !ram_csb0;
    assign wr_sel_s   = access_s && !ram_web0 && in_range_s;
    assign rd_sel_s   = access_s &&  ram_web0 && in_range_s;

`ifdef RAM_PARITY_EN
    logic [NLANES-1:0] par_mem_r [DEPTH];
    logic [NLANES-1:0] wr_par_s;
    logic [NLANES-1:0] rd_par_s;

    for (genvar g = 0; g < NLANES; g++) begin : g_lane_par
        sram_lane_parity u_wr_par (
            .lane_data   (ram_din0[lane_lo(g) +: LANE_W]),
            .lane_parity (wr_par_s[g])
        );
        sram_lane_parity u_rd_par (
            .lane_data   (rd_word_s[lane_lo(g) +: LANE_W]),
            .lane_parity (rd_par_s[g])
        );
    end

    // Any lane whose recomputed parity disagrees with the stored bit
    assign par_bad_s = |(rd_par_s ^ par_mem_r[idx_s]);
`else
    logic unused_parity_inj_s;
    assign unused_parity_inj_s = parity_inj;
    assign par_bad_s           = 1'b0;
`endif

    // Storage array: zeroed by the clear sweep, byte-masked writes when ready (no reset on contents)
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_r == ST_CLEAR) begin
                mem_r[clr_ptr_r] <= '0;
`ifdef RAM_PARITY_EN
                par_mem_r[clr_ptr_r] <= '0;
`endif
            end else if (wr_sel_s) begin
                for (int i = 0; i < NLANES; i++) begin
                    if (ram_wmask0[i]) begin
                        mem_r[idx_s][i*LANE_W +: LANE_W] <= ram_din0[i*LANE_W +: LANE_W];
`ifdef RAM_PARITY_EN
                        par_mem_r[idx_s][i] <= wr_par_s[i] ^ parity_inj;
`endif
                    end
                end
            end
        end
    end

    // Clear-sweep FSM, read data register and one-cycle status flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_CLEAR;
            clr_ptr_r    <= '0;
            dout_r       <= '0;
            init_busy_r  <= 1'b1;
            addr_err_r   <= 1'b0;
            parity_err_r <= 1'b0;
        end else begin
            addr_err_r   <= 1'b0;
            parity_err_r <= 1'b0;
            case (state_r)
                ST_CLEAR: begin
                    clr_ptr_r <= clr_ptr_r + 1'b1;
                    if (clr_ptr_r == LAST_PTR) begin
                        state_r     <= ST_READY;
                        init_busy_r <= 1'b0;
                    end
                end
                ST_READY: begin
                    if (access_s && !in_range_s) begin
                        addr_err_r <= 1'b1;
                        if (ram_web0) begin
                            dout_r <= '0;
                        end
                    end else if (rd_sel_s) begin
                        dout_r       <= rd_word_s;
                        parity_err_r <= par_bad_s;
                    end
                end
                default: begin
                    // Unreachable encoding: restart the sweep from a known point
                    state_r     <= ST_CLEAR;
                    clr_ptr_r   <= '0;
                    init_busy_r <= 1'b1;
                end
            endcase
        end
    end

    assign ram_dout0  = dout_r;
    assign init_busy  = init_busy_r;
    assign addr_err   = addr_err_r;
    assign parity_err = parity_err_r;

endmodule

// File: tb/tb_sram_1rw_responder.sv
// Self-checking bench for sram_1rw_responder: directed scenarios plus a randomized
// run, all checked against a word-array reference model held in the bench.
module tb_sram_1rw_responder;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;
`ifdef RAM_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ram_csb0;
    logic              ram_web0;
    logic [3:0]        ram_wmask0;
    logic [ADDR_W-1:0] ram_addr0;
    logic [DATA_W-1:0] ram_din0;
    logic [DATA_W-1:0] ram_dout0;
    logic              init_busy;
    logic              addr_err;
    logic              parity_inj;
    logic              parity_err;

    int tests = 0;
    int fails = 0;

    // Reference model: word contents and "lane parity corrupted" flags
    logic [DATA_W-1:0] model   [DEPTH];
    logic [3:0]        bad     [DEPTH];
    logic [DATA_W-1:0] exp_dout;
    logic              exp_aerr;
    logic              exp_perr;

    sram_1rw_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ram_csb0   (ram_csb0),
        .ram_web0   (ram_web0),
        .ram_wmask0 (ram_wmask0),
        .ram_addr0  (ram_addr0),
        .ram_din0   (ram_din0),
        .ram_dout0  (ram_dout0),
        .init_busy  (init_busy),
        .addr_err   (addr_err),
        .parity_inj (parity_inj),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            model[i] = '0;
            bad[i]   = '0;
        end
        exp_dout = '0;
        exp_aerr = 1'b0;
        exp_perr = 1'b0;
    endtask

    // One port access in the ready state; model updated from the port rules
    task automatic op(input logic csb, input logic web, input logic [3:0] mask,
                      input int addr, input logic [31:0] din, input logic inj);
        logic oob;
        ram_csb0   = csb;
        ram_web0   = web;
        ram_wmask0 = mask;
        ram_addr0  = ADDR_W'(addr);
        ram_din0   = din;
        parity_inj = inj;
        @(posedge clk);
        #1;
        oob      = (addr >= DEPTH);
        exp_aerr = 1'b0;
        exp_perr = 1'b0;
        if (!csb) begin
            exp_aerr = oob;
            if (!web) begin
                if (!oob) begin
                    for (int l = 0; l < 4; l++) begin
                        if (mask[l]) begin
                            model[addr][l*8 +: 8] = din[l*8 +: 8];
                            bad[addr][l]          = inj & PAR_EN;
                        end
                    end
                end
            end else begin
                exp_dout = oob ? 32'h0 : model[addr];
                exp_perr = !oob && (bad[addr] != 4'h0);
            end
        end
        ram_csb0   = 1'b1;
        parity_inj = 1'b0;
    endtask

    // Apply reset for one edge, release, and count cycles until the sweep ends
    task automatic reset_and_sweep(input int pre_cycles, output int busy_cycles, output logic quiet);
        busy_cycles = 0;
        quiet       = 1'b1;
        rst_n       = 1'b0;
        ram_csb0    = 1'b1;
        repeat (1) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 600; c++) begin
            ram_csb0   = 1'b0;
            ram_web0   = 1'($urandom_range(0, 1));
            ram_wmask0 = 4'hF;
            ram_addr0  = ADDR_W'($urandom_range(0, 511));
            ram_din0   = $urandom;
            @(posedge clk);
            #1;
            busy_cycles++;
            if (ram_dout0 !== 32'h0 || addr_err !== 1'b0) quiet = 1'b0;
            if (pre_cycles > 0 && busy_cycles == pre_cycles) break;
            if (init_busy !== 1'b1) break;
        end
        ram_csb0 = 1'b1;
    endtask

    task automatic test_reset();
        int   n;
        logic q;
        rst_n      = 1'b0;
        ram_csb0   = 1'b0;
        ram_web0   = 1'b1;
        ram_wmask0 = 4'hF;
        ram_addr0  = '0;
        ram_din0   = 32'hFFFF_FFFF;
        parity_inj = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (ram_dout0 !== 32'h0 || init_busy !== 1'b1 || addr_err !== 1'b0 || parity_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: dout=%h busy=%b aerr=%b perr=%b, required 0/1/0/0",
                     ram_dout0, init_busy, addr_err, parity_err);
        end
        reset_and_sweep(0, n, q);
        model_clear();
        tests++;
        if (n !== DEPTH || init_busy !== 1'b0) begin
            fails++;
            $display("FAIL clear_len: busy for %0d cycles (busy now %b), required %0d", n, init_busy, DEPTH);
        end
        tests++;
        if (!q) begin
            fails++;
            $display("FAIL clear_quiet: dout/addr_err moved during sweep, required 0/0");
        end
        op(1'b0, 1'b1, 4'h0, 5, 32'h0, 1'b0);
        tests++;
        if (ram_dout0 !== 32'h0) begin
            fails++;
            $display("FAIL read_after_clear: dout=%h, required 00000000", ram_dout0);
        end
    endtask

    task automatic test_byte_mask();
        op(1'b0, 1'b0, 4'hF, 3, 32'hDEAD_BEEF, 1'b0);
        tests++;
        if (ram_dout0 !== 32'h0) begin
            fails++;
            $display("FAIL no_write_through: dout=%h, required 00000000", ram_dout0);
        end
        op(1'b0, 1'b1, 4'h0, 3, 32'h0, 1'b0);
        tests++;
        if (ram_dout0 !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL full_write: dout=%h, required deadbeef", ram_dout0);
        end
        op(1'b0, 1'b0, 4'b0101, 3, 32'h1122_3344, 1'b0);
        op(1'b0, 1'b1, 4'h0, 3, 32'h0, 1'b0);
        tests++;
        if (ram_dout0 !== 32'hDE22_BE44) begin
            fails++;
            $display("FAIL masked_write: dout=%h, required de22be44", ram_dout0);
        end
        op(1'b0, 1'b0, 4'h0, 3, 32'h5555_5555, 1'b0);
        op(1'b0, 1'b1, 4'h0, 3, 32'h0, 1'b0);
        tests++;
        if (ram_dout0 !== 32'hDE22_BE44) begin
            fails++;
            $display("FAIL zero_mask: dout=%h, required de22be44", ram_dout0);
        end
        op(1'b1, 1'b1, 4'h0, 9, 32'h0, 1'b0);
        tests++;
        if (ram_dout0 !== 32'hDE22_BE44) begin
            fails++;
            $display("FAIL idle_hold: dout=%h, required de22be44", ram_dout0);
        end
    endtask

    task automatic test_out_of_range();
        op(1'b0, 1'b0, 4'hF, 0, 32'hA5A5_0001, 1'b0);
        op(1'b0, 1'b1, 4'h0, 3, 32'h0, 1'b0);
        op(1'b0, 1'b1, 4'h0, DEPTH, 32'h0, 1'b0);
        tests++;
        if (ram_dout0 !== 32'h0 || addr_err !== 1'b1) begin
            fails++;
            $display("FAIL oob_read: dout=%h aerr=%b, required 00000000/1", ram_dout0, addr_err);
        end
        op(1'b1, 1'b1, 4'h0, 0, 32'h0, 1'b0);
        tests++;
        if (addr_err !== 1'b0) begin
            fails++;
            $display("FAIL aerr_pulse: aerr=%b, required 0", addr_err);
        end
        op(1'b0, 1'b0, 4'hF, DEPTH, 32'h7777_7777, 1'b0);
        tests++;
        if (addr_err !== 1'b1) begin
            fails++;
            $display("FAIL oob_write_flag: aerr=%b, required 1", addr_err);
        end
        op(1'b0, 1'b1, 4'h0, 0, 32'h0, 1'b0);
        tests++;
        if (ram_dout0 !== 32'hA5A5_0001 || addr_err !== 1'b0) begin
            fails++;
            $display("FAIL no_alias: dout=%h aerr=%b, required a5a50001/0", ram_dout0, addr_err);
        end
    endtask

    task automatic test_random();
        int a;
        for (int n = 0; n < 300; n++) begin
            a = ($urandom_range(0, 9) == 0) ? int'($urandom_range(DEPTH, 511)) : int'($urandom_range(0, 15));
            op(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)), a, $urandom, 1'b0);
            tests++;
            if (ram_dout0 !== exp_dout || addr_err !== exp_aerr || parity_err !== exp_perr) begin
                fails++;
                $display("FAIL random[%0d]: dout=%h aerr=%b perr=%b, required %h/%b/%b",
                         n, ram_dout0, addr_err, parity_err, exp_dout, exp_aerr, exp_perr);
            end
        end
    endtask

    task automatic test_parity();
        op(1'b0, 1'b0, 4'b0010, 7, 32'h1234_5678, 1'b1);
        op(1'b0, 1'b1, 4'h0, 7, 32'h0, 1'b0);
        tests++;
        if (parity_err !== PAR_EN || ram_dout0 !== model[7]) begin
            fails++;
            $display("FAIL parity_inj: perr=%b dout=%h, required %b/%h", parity_err, ram_dout0, PAR_EN, model[7]);
        end
        op(1'b0, 1'b0, 4'b0010, 7, 32'h0000_9A00, 1'b0);
        op(1'b0, 1'b1, 4'h0, 7, 32'h0, 1'b0);
        tests++;
        if (parity_err !== 1'b0 || ram_dout0 !== model[7]) begin
            fails++;
            $display("FAIL parity_clean: perr=%b dout=%h, required 0/%h", parity_err, ram_dout0, model[7]);
        end
        op(1'b0, 1'b0, 4'b1000, DEPTH + 1, 32'h0, 1'b1);
        op(1'b0, 1'b1, 4'h0, DEPTH + 1, 32'h0, 1'b0);
        tests++;
        if (parity_err !== 1'b0) begin
            fails++;
            $display("FAIL parity_oob: perr=%b, required 0", parity_err);
        end
    endtask

    task automatic test_reset_mid_clear();
        int   n;
        logic q;
        op(1'b0, 1'b0, 4'hF, 3, 32'hCAFE_F00D, 1'b0);
        reset_and_sweep(10, n, q);
        tests++;
        if (init_busy !== 1'b1 || n !== 10) begin
            fails++;
            $display("FAIL mid_clear_busy: busy=%b after %0d cycles, required 1 after 10", init_busy, n);
        end
        reset_and_sweep(0, n, q);
        model_clear();
        tests++;
        if (n !== DEPTH || init_busy !== 1'b0) begin
            fails++;
            $display("FAIL restart_len: busy for %0d cycles, required %0d", n, DEPTH);
        end
        op(1'b0, 1'b1, 4'h0, 3, 32'h0, 1'b0);
        tests++;
        if (ram_dout0 !== 32'h0) begin
            fails++;
            $display("FAIL cleared_data: dout=%h, required 00000000", ram_dout0);
        end
    endtask

    initial begin
        test_reset();
        test_byte_mask();
        test_out_of_range();
        test_random();
        test_parity();
        test_reset_mid_clear();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
